// File: rtl/ysyx_22040386_dmem_slave_if.sv
// ysyx_22040386_dmem_slave_if
//   Request/response bus between the MEM-stage requester (master) and the
//   data-memory responder (slave).
//
//   Handshake rule for both channels: a transfer happens on a rising clock
//   edge where valid and ready are both high. The sender keeps valid high and
//   its payload stable until that edge. The receiver may raise or lower ready
//   at any time. Valid never waits on ready.
//
//   Request channel  (master -> slave): i_DMEM_req_valid / o_DMEM_req_ready,
//     payload i_DMEM_req_we, _addr, _wdata, _wmask, _size
//   Response channel (slave -> master): o_DMEM_resp_valid / i_DMEM_resp_ready,
//     payload o_DMEM_resp_rdata, o_DMEM_resp_err
interface ysyx_22040386_dmem_slave_if;
  logic        i_DMEM_req_valid;
  logic        o_DMEM_req_ready;
  logic        i_DMEM_req_we;
  logic [63:0] i_DMEM_req_addr;
  logic [63:0] i_DMEM_req_wdata;
  logic [7:0]  i_DMEM_req_wmask;
  logic [1:0]  i_DMEM_req_size;
  logic        o_DMEM_resp_valid;
  logic        i_DMEM_resp_ready;
  logic [63:0] o_DMEM_resp_rdata;
  logic        o_DMEM_resp_err;

  modport master (
    output i_DMEM_req_valid, i_DMEM_req_we, i_DMEM_req_addr,
           i_DMEM_req_wdata, i_DMEM_req_wmask, i_DMEM_req_size,
           i_DMEM_resp_ready,
    input  o_DMEM_req_ready, o_DMEM_resp_valid, o_DMEM_resp_rdata,
           o_DMEM_resp_err
  );

  modport slave (
    input  i_DMEM_req_valid, i_DMEM_req_we, i_DMEM_req_addr,
           i_DMEM_req_wdata, i_DMEM_req_wmask, i_DMEM_req_size,
           i_DMEM_resp_ready,
    output o_DMEM_req_ready, o_DMEM_resp_valid, o_DMEM_resp_rdata,
           o_DMEM_resp_err
  );
endinterface

// File: rtl/ysyx_22040386_dmem_slave.sv
// ysyx_22040386_dmem_slave
//   Data-memory responder for the load/store path. Accepts one read or
//   byte-masked write at a time, services it from an internal 64-bit-wide RAM
//   after LATENCY cycles and returns read data or a write acknowledge.
//
//   Ports:
//     i_DMEM_clk        clock, all state on the rising edge
//     i_DMEM_rst_n      asynchronous active-low reset
//     bus               ysyx_22040386_dmem_slave_if.slave (request/response)
//     o_DMEM_dbg_state  current FSM state (0 IDLE, 1 WAIT, 2 RESP)
//
//   Parameters: BASE_ADDR (byte address of word 0), DEPTH_LOG2 (log2 words),
//   LATENCY (request handshake to response valid, 1..15).
//
//   Optional feature macro: YSYX_22040386_DMEM_ALIGN_CHK_EN
//     defined   : misaligned half/word/double accesses report err, no write
//     undefined : size is ignored, err reflects only the range check
module ysyx_22040386_dmem_slave #(
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 2
) (
  input  logic                        i_DMEM_clk,
  input  logic                        i_DMEM_rst_n,
  ysyx_22040386_dmem_slave_if.slave   bus,
  output logic [1:0]                  o_DMEM_dbg_state
);

  localparam int          DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0]  CNT_LOAD  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [63:0] rdata_q;
  logic        err_q;

  logic        lat_we;
  logic [63:0] lat_addr;
  logic [63:0] lat_wdata;
  logic [7:0]  lat_wmask;
  logic [1:0]  lat_size;

  logic [63:0] mem [DEPTH];

  // Fields of the access being performed this cycle. With LATENCY=1 the
  // access happens on the handshake edge itself, so it must use the live
  // request rather than the (not yet loaded) latched copy.
  logic                  in_idle;
  logic                  hs;
  logic                  do_access;
  logic                  a_we;
  logic [63:0]           a_addr;
  logic [63:0]           a_wdata;
  logic [7:0]            a_wmask;
  logic [1:0]            a_size;
  logic [63:0]           a_offset;
  logic                  a_in_range;
  logic                  a_misalign;
  logic                  a_err;
  logic [DEPTH_LOG2-1:0] a_idx;
  logic [63:0]           a_rdata;

  assign in_idle   = (state == S_IDLE);
  assign hs        = in_idle && bus.i_DMEM_req_valid;
  assign do_access = (LATENCY == 1) ? hs : ((state == S_WAIT) && (cnt == 4'd0));

  assign a_we    = in_idle ? bus.i_DMEM_req_we    : lat_we;
  assign a_addr  = in_idle ? bus.i_DMEM_req_addr  : lat_addr;
  assign a_wdata = in_idle ? bus.i_DMEM_req_wdata : lat_wdata;
  assign a_wmask = in_idle ? bus.i_DMEM_req_wmask : lat_wmask;
  assign a_size  = in_idle ? bus.i_DMEM_req_size  : lat_size;

  // Checking the offset's upper bits instead of comparing against
  // BASE_ADDR + size keeps the test free of overflow near the top of memory.
  assign a_offset   = a_addr - BASE_ADDR;
  assign a_in_range = (a_addr >= BASE_ADDR) && (a_offset[63:DEPTH_LOG2+3] == '0);
  assign a_idx      = a_offset[DEPTH_LOG2+2:3];

`ifdef YSYX_22040386_DMEM_ALIGN_CHK_EN
  always_comb begin
    a_misalign = 1'b0;
    case (a_size)
      2'b01:   a_misalign = a_addr[0];
      2'b10:   a_misalign = (a_addr[1:0] != 2'b00);
      2'b11:   a_misalign = (a_addr[2:0] != 3'b000);
      default: a_misalign = 1'b0;
    endcase
  end
`else
  assign a_misalign = 1'b0;
`endif

  assign a_err   = !a_in_range || a_misalign;
  assign a_rdata = (!a_we && !a_err) ? mem[a_idx] : 64'd0;

  // RAM is deliberately not reset. Reset forces the FSM to IDLE, which drops
  // do_access, so a pending write never commits once reset is asserted.
  always_ff @(posedge i_DMEM_clk) begin
    if (do_access && a_we && !a_err) begin
      for (int i = 0; i < 8; i++) begin
        if (a_wmask[i]) mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge i_DMEM_clk or negedge i_DMEM_rst_n) begin
    if (!i_DMEM_rst_n) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= 64'd0;
      err_q        <= 1'b0;
      lat_we       <= 1'b0;
      lat_addr     <= 64'd0;
      lat_wdata    <= 64'd0;
      lat_wmask    <= 8'd0;
      lat_size     <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hs) begin
            lat_we      <= bus.i_DMEM_req_we;
            lat_addr    <= bus.i_DMEM_req_addr;
            lat_wdata   <= bus.i_DMEM_req_wdata;
            lat_wmask   <= bus.i_DMEM_req_wmask;
            lat_size    <= bus.i_DMEM_req_size;
            req_ready_q <= 1'b0;
            if (do_access) begin
              state        <= S_RESP;
              resp_valid_q <= 1'b1;
              rdata_q      <= a_rdata;
              err_q        <= a_err;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (do_access) begin
            state        <= S_RESP;
            resp_valid_q <= 1'b1;
            rdata_q      <= a_rdata;
            err_q        <= a_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (bus.i_DMEM_resp_ready) begin
            state        <= S_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
          end
        end
        default: begin
          state        <= S_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_DMEM_req_ready  = req_ready_q;
  assign bus.o_DMEM_resp_valid = resp_valid_q;
  assign bus.o_DMEM_resp_rdata = rdata_q;
  assign bus.o_DMEM_resp_err   = err_q;
  assign o_DMEM_dbg_state      = state;

endmodule

// File: tb/tb_ysyx_22040386_dmem_slave.sv
// tb_ysyx_22040386_dmem_slave
//   Two responders: dut_a with LATENCY=2 and dut_b with LATENCY=3, sharing
//   request payload wires; only the selected one sees req_valid. Expected
//   results come from a per-DUT word-addressed associative memory model.
module tb_ysyx_22040386_dmem_slave;

  localparam logic [63:0] BASE      = 64'h8000_0000;
  localparam int          DLOG2     = 12;
  localparam logic [63:0] RAM_BYTES = 64'd8 << DLOG2;

  // clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus signals
  logic        sel;
  logic        valid;
  logic        we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [7:0]  wmask;
  logic [1:0]  size;
  logic        resp_ready;

  ysyx_22040386_dmem_slave_if bus_a ();
  ysyx_22040386_dmem_slave_if bus_b ();
  logic [1:0] dbg_a;
  logic [1:0] dbg_b;

  assign bus_a.i_DMEM_req_valid  = valid & ~sel;
  assign bus_a.i_DMEM_req_we     = we;
  assign bus_a.i_DMEM_req_addr   = addr;
  assign bus_a.i_DMEM_req_wdata  = wdata;
  assign bus_a.i_DMEM_req_wmask  = wmask;
  assign bus_a.i_DMEM_req_size   = size;
  assign bus_a.i_DMEM_resp_ready = resp_ready;
  assign bus_b.i_DMEM_req_valid  = valid & sel;
  assign bus_b.i_DMEM_req_we     = we;
  assign bus_b.i_DMEM_req_addr   = addr;
  assign bus_b.i_DMEM_req_wdata  = wdata;
  assign bus_b.i_DMEM_req_wmask  = wmask;
  assign bus_b.i_DMEM_req_size   = size;
  assign bus_b.i_DMEM_resp_ready = resp_ready;

  ysyx_22040386_dmem_slave #(.BASE_ADDR(BASE), .DEPTH_LOG2(DLOG2), .LATENCY(2)) dut_a (
    .i_DMEM_clk(clk), .i_DMEM_rst_n(rst_n), .bus(bus_a.slave), .o_DMEM_dbg_state(dbg_a)
  );
  ysyx_22040386_dmem_slave #(.BASE_ADDR(BASE), .DEPTH_LOG2(DLOG2), .LATENCY(3)) dut_b (
    .i_DMEM_clk(clk), .i_DMEM_rst_n(rst_n), .bus(bus_b.slave), .o_DMEM_dbg_state(dbg_b)
  );

  logic        obs_req_ready;
  logic        obs_resp_valid;
  logic [63:0] obs_rdata;
  logic        obs_err;
  logic [1:0]  obs_state;
  assign obs_req_ready  = sel ? bus_b.o_DMEM_req_ready  : bus_a.o_DMEM_req_ready;
  assign obs_resp_valid = sel ? bus_b.o_DMEM_resp_valid : bus_a.o_DMEM_resp_valid;
  assign obs_rdata      = sel ? bus_b.o_DMEM_resp_rdata : bus_a.o_DMEM_resp_rdata;
  assign obs_err        = sel ? bus_b.o_DMEM_resp_err   : bus_a.o_DMEM_resp_err;
  assign obs_state      = sel ? dbg_b : dbg_a;

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] model_mem [longint];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic bit in_range(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + RAM_BYTES);
  endfunction

  function automatic bit misaligned(input logic [63:0] a, input logic [1:0] sz);
`ifdef YSYX_22040386_DMEM_ALIGN_CHK_EN
    return (sz == 2'b01 && a[0] != 1'b0) ||
           (sz == 2'b10 && a[1:0] != 2'b00) ||
           (sz == 2'b11 && a[2:0] != 3'b000);
`else
    return (a[0] & 1'b0) | (sz[0] & 1'b0);
`endif
  endfunction

  function automatic longint key_of(input bit s, input logic [63:0] a);
    return longint'((a - BASE) / 8) + (s ? 64'sd1 << 40 : 64'sd0);
  endfunction

  // driver: one full transaction with latency, hold-stability and release checks
  task automatic txn(input bit s, input bit we_i, input logic [63:0] a,
                     input logic [63:0] wd, input logic [7:0] wm, input logic [1:0] sz,
                     input int hold, output logic [63:0] got);
    bit          e;
    bit          known;
    logic [63:0] er;
    logic [63:0] cur;
    longint      k;
    int          t;
    int          lat;
    lat   = s ? 3 : 2;
    e     = !in_range(a) || misaligned(a, sz);
    known = 1'b1;
    er    = 64'd0;
    k     = key_of(s, a);
    if (!e && !we_i) begin
      if (model_mem.exists(k)) er = model_mem[k];
      else known = 1'b0;
    end
    if (!e && we_i) begin
      cur = model_mem.exists(k) ? model_mem[k] : 64'd0;
      for (int b = 0; b < 8; b++)
        if (wm[b]) cur[8*b +: 8] = wd[8*b +: 8];
      // A partially written unknown word stays unknown to the model.
      if (model_mem.exists(k) || wm == 8'hFF) model_mem[k] = cur;
    end

    @(negedge clk);
    sel = s;
    t = 0;
    while (!obs_req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("req_ready_idle", {63'd0, obs_req_ready}, 64'd1);
    valid = 1'b1; we = we_i; addr = a; wdata = wd; wmask = wm; size = sz;
    @(posedge clk);
    #1;
    valid = 1'b0;
    we = $urandom_range(1); addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
    t = 0;
    while (!obs_resp_valid && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("latency", 64'(t), 64'(lat));
    check("req_ready_busy", {63'd0, obs_req_ready}, 64'd0);
    check("err", {63'd0, obs_err}, {63'd0, e});
    if (known) check("rdata", obs_rdata, er);
    got = obs_rdata;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check("hold_valid", {63'd0, obs_resp_valid}, 64'd1);
      check("hold_rdata", obs_rdata, got);
      check("hold_err", {63'd0, obs_err}, {63'd0, e});
      check("hold_req_ready", {63'd0, obs_req_ready}, 64'd0);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_req_ready", {63'd0, obs_req_ready}, 64'd1);
    check("release_resp_valid", {63'd0, obs_resp_valid}, 64'd0);
    resp_ready = 1'b0;
  endtask

  logic [63:0] got;
  logic [63:0] a_r;
  logic [63:0] exp_w0;

  initial begin
    rst_n = 1'b0; sel = 1'b0; valid = 1'b0; we = 1'b0; addr = 64'd0;
    wdata = 64'd0; wmask = 8'd0; size = 2'd0; resp_ready = 1'b0;
    #22;
    check("rst_req_ready", {63'd0, obs_req_ready}, 64'd1);
    check("rst_resp_valid", {63'd0, obs_resp_valid}, 64'd0);
    check("rst_rdata", obs_rdata, 64'd0);
    check("rst_err", {63'd0, obs_err}, 64'd0);
    check("rst_state", {62'd0, obs_state}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic write/read, byte merge
    txn(0, 1, 64'h8000_0000, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, 2'b11, 0, got);
    txn(0, 1, 64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 2'b11, 0, got);
    txn(0, 0, 64'h8000_0008, 64'd0, 8'h00, 2'b11, 0, got);
    check("dir_read", got, 64'h1122_3344_5566_7788);
    txn(0, 1, 64'h8000_0008, 64'h0000_0000_AABB_0000, 8'h0C, 2'b10, 0, got);
    txn(0, 0, 64'h8000_0008, 64'd0, 8'h00, 2'b11, 0, got);
    check("dir_merge", got, 64'h1122_3344_AABB_7788);

    // range errors, then word 0 untouched
    txn(0, 0, 64'h7FFF_FFF8, 64'd0, 8'h00, 2'b11, 0, got);
    txn(0, 0, BASE + RAM_BYTES, 64'd0, 8'h00, 2'b11, 0, got);
    txn(0, 1, 64'h7FFF_FFF8, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 2'b11, 0, got);
    txn(0, 0, 64'h8000_0000, 64'd0, 8'h00, 2'b11, 0, got);
    check("dir_word0", got, 64'hA5A5_A5A5_A5A5_A5A5);

    // zero-mask write is acknowledged and changes nothing
    txn(0, 1, 64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 2'b11, 0, got);
    txn(0, 0, 64'h8000_0008, 64'd0, 8'h00, 2'b11, 0, got);
    check("dir_zero_mask", got, 64'h1122_3344_AABB_7788);

    // backpressure for 5 cycles
    txn(0, 0, 64'h8000_0008, 64'd0, 8'h00, 2'b11, 5, got);

    // reset one cycle after a write handshake on the LATENCY=3 instance
    txn(1, 1, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 8'hFF, 2'b11, 0, got);
    @(negedge clk);
    sel = 1'b1; valid = 1'b1; we = 1'b1; addr = 64'h8000_0010;
    wdata = 64'hFEED_FACE_CAFE_F00D; wmask = 8'hFF; size = 2'b11;
    @(posedge clk);
    #1;
    valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_resp_valid", {63'd0, obs_resp_valid}, 64'd0);
    check("midrst_state", {62'd0, obs_state}, 64'd0);
    check("midrst_req_ready", {63'd0, obs_req_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    txn(1, 0, 64'h8000_0010, 64'd0, 8'h00, 2'b11, 0, got);
    check("midrst_old_data", got, 64'h0123_4567_89AB_CDEF);

    // half-word write at odd address
    txn(0, 1, 64'h8000_0001, 64'h0000_0000_00CC_DD00, 8'h06, 2'b01, 0, got);
`ifdef YSYX_22040386_DMEM_ALIGN_CHK_EN
    exp_w0 = 64'hA5A5_A5A5_A5A5_A5A5;
`else
    exp_w0 = 64'hA5A5_A5A5_A5CC_DDA5;
`endif
    txn(0, 0, 64'h8000_0000, 64'd0, 8'h00, 2'b11, 0, got);
    check("align_word0", got, exp_w0);

    // fill words 2..15 then random traffic
    for (int i = 2; i < 16; i++)
      txn(0, 1, BASE + 64'(8 * i), {$urandom, $urandom}, 8'hFF, 2'b11, 0, got);
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(7))
        0:       a_r = BASE - 64'(8 * $urandom_range(1, 4)) + 64'($urandom_range(7));
        1:       a_r = BASE + RAM_BYTES + 64'(8 * $urandom_range(0, 4)) + 64'($urandom_range(7));
        default: a_r = BASE + 64'(8 * $urandom_range(15)) + 64'($urandom_range(7));
      endcase
      txn(0, 1'($urandom_range(1)), a_r, {$urandom, $urandom}, 8'($urandom_range(255)),
          2'($urandom_range(3)), $urandom_range(2), got);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // global bound so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout: observed running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
